// File: rtl/class_word_gen.sv
// class_word_gen: emits bursts of 5-bit words that belong to one adjacency
// class ("00" pair or "11" pair) over a valid/ready handshake, together with
// the latched selection and mode for the downstream class counter.
module class_word_gen (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       start,
    input  logic       selection,
    input  logic       mode,
    input  logic [4:0] count,
    input  logic       ready,
    output logic [4:0] word,
    output logic       word_valid,
    output logic       sel_out,
    output logic       mode_out,
    output logic       busy,
    output logic       done,
    output logic [4:0] sent
);

    typedef enum logic [1:0] {StIdle, StSearch, StSend, StDone} state_e;

    state_e     state_q, state_d;
    logic [4:0] cursor_q, cursor_d;
    logic [4:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       sel_q, sel_d;
    logic       mode_q, mode_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] sent_q, sent_d;

    logic       hit00;
    logic       hit11;
    logic       match;
    logic [4:0] sent_inc;

    // Class membership of the cursor: any adjacent pair of zeros / of ones.
    always_comb begin
        hit00    = |(~cursor_q[3:0] & ~cursor_q[4:1]);
        hit11    = |(cursor_q[3:0] & cursor_q[4:1]);
        match    = sel_q ? hit11 : hit00;
        sent_inc = sent_q + 5'd1;
    end

    // State and datapath registers; reset aborts any burst at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            cursor_q <= 5'd0;
            word_q   <= 5'd0;
            valid_q  <= 1'b0;
            sel_q    <= 1'b0;
            mode_q   <= 1'b0;
            cnt_q    <= 5'd0;
            sent_q   <= 5'd0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            sent_q   <= sent_d;
        end
    end

    // Next-state logic: search one cursor per cycle, hold word until accepted.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        word_d   = word_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        sent_d   = sent_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sel_d    = selection;
                    mode_d   = mode;
                    cnt_d    = count;
                    cursor_d = 5'd0;
                    sent_d   = 5'd0;
                    word_d   = 5'd0;
                    state_d  = (count == 5'd0) ? StDone : StSearch;
                end
            end
            StSearch: begin
                if (match) begin
                    word_d  = cursor_q;
                    valid_d = 1'b1;
                    state_d = StSend;
                end else begin
                    cursor_d = cursor_q + 5'd1;
                end
            end
            StSend: begin
                if (ready) begin
                    valid_d  = 1'b0;
                    cursor_d = cursor_q + 5'd1;
                    sent_d   = sent_inc;
                    state_d  = (sent_inc == cnt_q) ? StDone : StSearch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        word       = word_q;
        word_valid = valid_q;
        sel_out    = sel_q;
        mode_out   = mode_q;
        sent       = sent_q;
        busy       = (state_q == StSearch) || (state_q == StSend);
        done       = (state_q == StDone);
    end

endmodule

// File: tb/tb_class_word_gen.sv
// Directed bench for class_word_gen with hand-computed word lists and timing.
module tb_class_word_gen;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       start = 1'b0;
    logic       selection = 1'b0;
    logic       mode = 1'b0;
    logic [4:0] count = 5'd0;
    logic       ready = 1'b0;
    logic [4:0] word;
    logic       word_valid;
    logic       sel_out;
    logic       mode_out;
    logic       busy;
    logic       done;
    logic [4:0] sent;

    class_word_gen dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .start      (start),
        .selection  (selection),
        .mode       (mode),
        .count      (count),
        .ready      (ready),
        .word       (word),
        .word_valid (word_valid),
        .sel_out    (sel_out),
        .mode_out   (mode_out),
        .busy       (busy),
        .done       (done),
        .sent       (sent)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_q[$];
    int          got_q[$];
    int          done_idx;
    int          done_cnt;
    int          first_valid;
    int          sent_at_done;
    int          busy_at_done;
    int          sel_at_done;
    int          mode_at_done;
    logic [31:0] valid_mask;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Compare accepted words against exp_q.
    task automatic check_words(input string tag);
        check_eq({tag, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    // Run one burst; inputs change 1 time unit after the edge, outputs are
    // observed there too. Index 0 is the cycle right after the start edge.
    task automatic run_burst(input logic s, input logic m, input logic [4:0] c,
                             input int stall_idx, input int stall_len, input bit poke);
        int         idx;
        int         stall_ctr;
        logic [4:0] held;
        idx = 0;
        stall_ctr = 0;
        held = 5'd0;
        got_q.delete();
        done_idx = -1;
        done_cnt = 0;
        first_valid = -1;
        valid_mask = 32'd0;
        sent_at_done = -1;
        busy_at_done = -1;
        sel_at_done = -1;
        mode_at_done = -1;
        start = 1'b1;
        selection = s;
        mode = m;
        count = c;
        ready = 1'b1;
        @(posedge CLK); #1;
        // Disturb the latched inputs; they must have no effect now.
        start = 1'b0;
        selection = ~s;
        mode = ~m;
        count = ~c;
        forever begin
            if (word_valid) begin
                if (first_valid < 0) first_valid = idx;
                if (idx < 32) valid_mask[idx] = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx = idx;
                    sent_at_done = int'(sent);
                    busy_at_done = int'(busy);
                    sel_at_done = int'(sel_out);
                    mode_at_done = int'(mode_out);
                end
            end
            if (stall_ctr > 0 && stall_ctr < stall_len) begin
                check_eq("hold_valid", word_valid, 1);
                check_eq("hold_word", word, held);
            end
            if (word_valid && got_q.size() == stall_idx && stall_ctr < stall_len) begin
                if (stall_ctr == 0) held = word;
                ready = 1'b0;
                stall_ctr++;
            end else begin
                ready = 1'b1;
                if (word_valid) got_q.push_back(int'(word));
            end
            start = (poke && done_idx < 0) ? (idx % 3 == 1) : 1'b0;
            if ((done_idx >= 0 && idx >= done_idx + 1) || idx >= 300) break;
            @(posedge CLK); #1;
            idx++;
        end
        start = 1'b0;
        ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_word"}, word, 0);
        check_eq({tag, "_valid"}, word_valid, 0);
        check_eq({tag, "_sel"}, sel_out, 0);
        check_eq({tag, "_mode"}, mode_out, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_sent"}, sent, 0);
    endtask

    initial begin
        int found;

        // Power-up reset
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("por");
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Reset in the middle of SEND while word 7 (class 1) is pending
        start = 1'b1;
        selection = 1'b1;
        mode = 1'b1;
        count = 5'd10;
        ready = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (word_valid && word == 5'd7) begin
                found = 1;
                ready = 1'b0;
            end else begin
                @(posedge CLK); #1;
            end
        end
        check_eq("rst_found7", found, 1);
        @(posedge CLK); #1;
        check_eq("rst_held_valid", word_valid, 1);
        check_eq("rst_held_sel", sel_out, 1);
        #2 RESET_N = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Class 0, count 3, mode 1: words 0,1,2, valid at idx 1,3,5, done at 6
        run_burst(1'b0, 1'b1, 5'd3, -1, 0, 1'b0);
        exp_q = '{0, 1, 2};
        check_words("c0n3");
        check_eq("c0n3_vmask", valid_mask, 32'h0000_002A);
        check_eq("c0n3_done_idx", done_idx, 6);
        check_eq("c0n3_done_cnt", done_cnt, 1);
        check_eq("c0n3_sent", sent_at_done, 3);
        check_eq("c0n3_busy_at_done", busy_at_done, 0);
        check_eq("c0n3_sel", sel_at_done, 0);
        check_eq("c0n3_mode", mode_at_done, 1);
        check_eq("c0n3_sent_hold", sent, 3);

        // Class 1, count 2: three cursors skipped, words 3 then 6
        run_burst(1'b1, 1'b0, 5'd2, -1, 0, 1'b0);
        exp_q = '{3, 6};
        check_words("c1n2");
        check_eq("c1n2_first_valid", first_valid, 4);
        check_eq("c1n2_vmask", valid_mask, 32'h0000_0110);
        check_eq("c1n2_done_idx", done_idx, 9);
        check_eq("c1n2_done_cnt", done_cnt, 1);
        check_eq("c1n2_sent", sent_at_done, 2);
        check_eq("c1n2_sel", sel_at_done, 1);
        check_eq("c1n2_mode", mode_at_done, 0);

        // Class 0, count 4, ready low for 5 cycles on the second word
        run_burst(1'b0, 1'b0, 5'd4, 1, 5, 1'b0);
        exp_q = '{0, 1, 2, 3};
        check_words("c0stall");
        check_eq("c0stall_done_cnt", done_cnt, 1);
        check_eq("c0stall_sent", sent_at_done, 4);
        check_eq("c0stall_word_hold", word, 3);

        // Class 1, count 21: wraps after 31; start pulses during burst ignored
        run_burst(1'b1, 1'b1, 5'd21, -1, 0, 1'b1);
        exp_q = '{3, 6, 7, 11, 12, 13, 14, 15, 19, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31,
                  3, 6};
        check_words("c1wrap");
        check_eq("c1wrap_done_cnt", done_cnt, 1);
        check_eq("c1wrap_sent", sent_at_done, 21);
        check_eq("c1wrap_idle_busy", busy, 0);

        // count 0: done one cycle after start, no valid
        run_burst(1'b1, 1'b0, 5'd0, -1, 0, 1'b0);
        check_eq("n0_done_idx", done_idx, 0);
        check_eq("n0_done_cnt", done_cnt, 1);
        check_eq("n0_vmask", valid_mask, 0);
        check_eq("n0_sent", sent_at_done, 0);
        check_eq("n0_busy", busy_at_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
